load_store_unit: RTL and testbench

Memory-stage load/store unit for the RV32I core. Consumes the effective address computed by the execute-stage ALU plus the load/store operation code, then runs a request/grant/response transaction on the data-memory port. Stores get byte-lane alignment; loads get byte/halfword extraction and sign/zero extension. Results are delivered to the writeback stage.

---
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage load/store unit.
// Aligns store data and byte enables onto the word-wide data-memory port,
// runs the request/grant/response handshake, and sign/zero-extends load
// results for writeback. Misaligned halfword/word accesses are rejected
// with a one-cycle pulse and never reach memory.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  mem_operation,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_index,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic [31:0] misaligned_addr
);

    // Operation codes shared with the execute stage (isa.svh values).
    localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h20;
    localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h21;
    localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h22;
    localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h23;
    localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h24;
    localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h28;
    localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h29;
    localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h2A;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [1:0]  op_size_q, op_size_d;
    logic        op_unsigned_q, op_unsigned_d;
    logic [1:0]  offset_q, offset_d;
    logic [4:0]  load_rd_q, load_rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] misaligned_addr_q, misaligned_addr_d;

    logic        is_load;
    logic        is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        access_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] load_result;

    // Decode the incoming operation into size, direction and lane layout.
    always_comb begin
        is_load      = 1'b0;
        is_store     = 1'b0;
        req_size     = SIZE_BYTE;
        req_unsigned = 1'b0;
        case (mem_operation)
            ALU_OPERATIONS_LB:  begin is_load = 1'b1; req_size = SIZE_BYTE; end
            ALU_OPERATIONS_LH:  begin is_load = 1'b1; req_size = SIZE_HALF; end
            ALU_OPERATIONS_LW:  begin is_load = 1'b1; req_size = SIZE_WORD; end
            ALU_OPERATIONS_LBU: begin is_load = 1'b1; req_size = SIZE_BYTE; req_unsigned = 1'b1; end
            ALU_OPERATIONS_LHU: begin is_load = 1'b1; req_size = SIZE_HALF; req_unsigned = 1'b1; end
            ALU_OPERATIONS_SB:  begin is_store = 1'b1; req_size = SIZE_BYTE; end
            ALU_OPERATIONS_SH:  begin is_store = 1'b1; req_size = SIZE_HALF; end
            ALU_OPERATIONS_SW:  begin is_store = 1'b1; req_size = SIZE_WORD; end
            default: ;
        endcase

        access_misaligned = ((req_size == SIZE_HALF) && address[0]) ||
                            ((req_size == SIZE_WORD) && (address[1:0] != 2'b00));

        case (req_size)
            SIZE_BYTE: begin
                req_be    = 4'b0001 << address[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                req_be    = address[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{store_data[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = store_data;
            end
        endcase
    end

    // Pick the addressed byte/halfword from the returned word and extend it.
    always_comb begin
        case (offset_q)
            2'd0:    rsp_byte = dmem_rdata[7:0];
            2'd1:    rsp_byte = dmem_rdata[15:8];
            2'd2:    rsp_byte = dmem_rdata[23:16];
            default: rsp_byte = dmem_rdata[31:24];
        endcase
        rsp_half = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (op_size_q)
            SIZE_BYTE: load_result = op_unsigned_q ? {24'd0, rsp_byte}
                                                   : {{24{rsp_byte[7]}}, rsp_byte};
            SIZE_HALF: load_result = op_unsigned_q ? {16'd0, rsp_half}
                                                   : {{16{rsp_half[15]}}, rsp_half};
            default:   load_result = dmem_rdata;
        endcase
    end

    // Next-state and next-register logic for the request/grant/response FSM.
    always_comb begin
        state_d           = state_q;
        dmem_we_d         = dmem_we_q;
        dmem_addr_d       = dmem_addr_q;
        dmem_be_d         = dmem_be_q;
        dmem_wdata_d      = dmem_wdata_q;
        op_size_d         = op_size_q;
        op_unsigned_d     = op_unsigned_q;
        offset_d          = offset_q;
        load_rd_d         = load_rd_q;
        wb_valid_d        = 1'b0;
        wb_rd_d           = wb_rd_q;
        wb_data_d         = wb_data_q;
        misaligned_d      = 1'b0;
        misaligned_addr_d = misaligned_addr_q;

        case (state_q)
            IDLE: begin
                if (req_valid && (is_load || is_store)) begin
                    if (access_misaligned) begin
                        misaligned_d      = 1'b1;
                        misaligned_addr_d = address;
                    end else begin
                        state_d       = REQ;
                        dmem_we_d     = is_store;
                        dmem_addr_d   = {address[31:2], 2'b00};
                        dmem_be_d     = req_be;
                        dmem_wdata_d  = req_wdata;
                        op_size_d     = req_size;
                        op_unsigned_d = req_unsigned;
                        offset_d      = address[1:0];
                        load_rd_d     = rd_index;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d = dmem_we_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = load_rd_q;
                    wb_data_d  = load_result;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= 32'd0;
            dmem_be_q         <= 4'd0;
            dmem_wdata_q      <= 32'd0;
            op_size_q         <= SIZE_BYTE;
            op_unsigned_q     <= 1'b0;
            offset_q          <= 2'd0;
            load_rd_q         <= 5'd0;
            wb_valid_q        <= 1'b0;
            wb_rd_q           <= 5'd0;
            wb_data_q         <= 32'd0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= 32'd0;
        end else begin
            state_q           <= state_d;
            dmem_we_q         <= dmem_we_d;
            dmem_addr_q       <= dmem_addr_d;
            dmem_be_q         <= dmem_be_d;
            dmem_wdata_q      <= dmem_wdata_d;
            op_size_q         <= op_size_d;
            op_unsigned_q     <= op_unsigned_d;
            offset_q          <= offset_d;
            load_rd_q         <= load_rd_d;
            wb_valid_q        <= wb_valid_d;
            wb_rd_q           <= wb_rd_d;
            wb_data_q         <= wb_data_d;
            misaligned_q      <= misaligned_d;
            misaligned_addr_q <= misaligned_addr_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign dmem_req        = (state_q == REQ);
    assign dmem_we         = dmem_we_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_be         = dmem_be_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign misaligned      = misaligned_q;
    assign misaligned_addr = misaligned_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. Stimulus pushes
// expected writeback/misaligned responses into a scoreboard queue; a monitor
// pops and compares whenever the DUT pulses wb_valid or misaligned.
module tb_load_store_unit;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h22;
    localparam logic [7:0] OP_LBU = 8'h23;
    localparam logic [7:0] OP_LHU = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  mem_operation;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [4:0]  rd_index;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic [31:0] misaligned_addr;

    typedef struct {
        bit          isMisaligned;
        logic [4:0]  rd;
        logic [31:0] value;
    } expect_t;

    expect_t sbQueue[$];
    int assertCount = 0;
    int failCount   = 0;

    load_store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .mem_operation   (mem_operation),
        .address         (address),
        .store_data      (store_data),
        .rd_index        (rd_index),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .misaligned      (misaligned),
        .misaligned_addr (misaligned_addr)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRequestLanes(input logic expWe, input logic [31:0] expAddr,
                                     input logic [3:0] expBe, input logic [31:0] expWdata);
        checkOutput("dmem_req", {31'd0, dmem_req}, 32'd1);
        checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, expWe});
        checkOutput("dmem_addr", dmem_addr, expAddr);
        checkOutput("dmem_be", {28'd0, dmem_be}, {28'd0, expBe});
        if (expWe) checkOutput("dmem_wdata", dmem_wdata, expWdata);
    endtask

    // Issue one operation, play the memory side, and check the port each cycle.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [4:0] rd,
                                 input int gntDelay, input int rvDelay,
                                 input logic [31:0] rdata, input bit expMis,
                                 input logic [3:0] expBe, input logic [31:0] expWdata,
                                 input logic [31:0] expWb, input bit earlyRvalid);
        int guard;
        expect_t e;
        bit isStore;
        isStore = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("req_ready_before_issue", {31'd0, req_ready}, 32'd1);

        if (expMis) begin
            e.isMisaligned = 1'b1; e.rd = 5'd0; e.value = addr;
            sbQueue.push_back(e);
        end else if (!isStore) begin
            e.isMisaligned = 1'b0; e.rd = rd; e.value = expWb;
            sbQueue.push_back(e);
        end

        req_valid = 1'b1; mem_operation = op; address = addr;
        store_data = sdata; rd_index = rd;
        tick();
        req_valid = 1'b0;

        if (expMis) begin
            @(negedge clk);
            checkOutput("mis_no_dmem_req", {31'd0, dmem_req}, 32'd0);
            checkOutput("mis_req_ready", {31'd0, req_ready}, 32'd1);
            tick();
            @(negedge clk);
            checkOutput("mis_single_pulse", {31'd0, misaligned}, 32'd0);
            checkOutput("mis_no_dmem_req_after", {31'd0, dmem_req}, 32'd0);
            return;
        end

        for (int i = 0; i < gntDelay; i++) begin
            @(negedge clk);
            checkRequestLanes(isStore, {addr[31:2], 2'b00}, expBe, expWdata);
            tick();
        end
        dmem_gnt = 1'b1;
        if (earlyRvalid) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'hBADC0DE5;
        end
        @(negedge clk);
        checkRequestLanes(isStore, {addr[31:2], 2'b00}, expBe, expWdata);
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;

        if (isStore) begin
            @(negedge clk);
            checkOutput("store_done_ready", {31'd0, req_ready}, 32'd1);
            checkOutput("store_no_wb", {31'd0, wb_valid}, 32'd0);
            return;
        end

        for (int i = 0; i < rvDelay; i++) begin
            @(negedge clk);
            checkOutput("wait_rsp_not_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("wait_rsp_no_req", {31'd0, dmem_req}, 32'd0);
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        @(negedge clk);
        checkOutput("load_wb_timing", {31'd0, wb_valid}, 32'd1);
        checkOutput("load_done_ready", {31'd0, req_ready}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("wb_single_pulse", {31'd0, wb_valid}, 32'd0);
    endtask

    // Scoreboard monitor: compare every response pulse against the queue head.
    always @(negedge clk) begin
        if (rst_n && (wb_valid || misaligned)) begin
            expect_t e;
            checkOutput("pulses_exclusive", {31'd0, wb_valid & misaligned}, 32'd0);
            if (sbQueue.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_pulse: got wb_valid=%0b misaligned=%0b, expected none",
                         wb_valid, misaligned);
            end else begin
                e = sbQueue.pop_front();
                if (e.isMisaligned) begin
                    checkOutput("sb_misaligned", {31'd0, misaligned}, 32'd1);
                    checkOutput("sb_misaligned_addr", misaligned_addr, e.value);
                end else begin
                    checkOutput("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
                    checkOutput("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    checkOutput("sb_wb_data", wb_data, e.value);
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_operation = 8'd0; address = 32'd0;
        store_data = 32'd0; rd_index = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("reset_dmem_addr", dmem_addr, 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] stores");
        applyStimulus(OP_SW, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0, 0, 4'b1111, 32'hDEADBEEF, 32'd0, 0);
        applyStimulus(OP_SB, 32'h103, 32'h000000A5, 5'd0, 3, 0, 32'd0, 0, 4'b1000, 32'hA5A5A5A5, 32'd0, 0);
        applyStimulus(OP_SH, 32'h206, 32'h00001234, 5'd0, 1, 0, 32'd0, 0, 4'b1100, 32'h12341234, 32'd0, 0);

        $display("[TB] loads");
        applyStimulus(OP_LB,  32'h102, 32'd0, 5'd7,  0, 1, 32'h00F00000, 0, 4'b0100, 32'd0, 32'hFFFFFFF0, 0);
        applyStimulus(OP_LBU, 32'h102, 32'd0, 5'd7,  0, 1, 32'h00F00000, 0, 4'b0100, 32'd0, 32'h000000F0, 0);
        applyStimulus(OP_LH,  32'h202, 32'd0, 5'd3,  0, 0, 32'h80010000, 0, 4'b1100, 32'd0, 32'hFFFF8001, 0);
        applyStimulus(OP_LHU, 32'h202, 32'd0, 5'd4,  2, 0, 32'h80010000, 0, 4'b1100, 32'd0, 32'h00008001, 0);
        applyStimulus(OP_LW,  32'h200, 32'd0, 5'd9,  0, 0, 32'h80010000, 0, 4'b1111, 32'd0, 32'h80010000, 1);
        applyStimulus(OP_LB,  32'h101, 32'd0, 5'd31, 0, 0, 32'h00007F00, 0, 4'b0010, 32'd0, 32'h0000007F, 0);

        $display("[TB] misaligned");
        applyStimulus(OP_LW, 32'h101, 32'd0, 5'd1, 0, 0, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 0);
        applyStimulus(OP_SH, 32'h205, 32'h0000BEEF, 5'd0, 0, 0, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 0);

        $display("[TB] ignored operation");
        req_valid = 1'b1; mem_operation = 8'h00; address = 32'h400;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("ignored_stays_idle", {31'd0, req_ready}, 32'd1);
        checkOutput("ignored_no_req", {31'd0, dmem_req}, 32'd0);

        $display("[TB] reset during WAIT_RSP");
        tick();
        req_valid = 1'b1; mem_operation = OP_LW; address = 32'h300; rd_index = 5'd12;
        tick();
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("in_wait_rsp", {31'd0, req_ready}, 32'd0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
        checkOutput("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_misaligned_addr", misaligned_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        tick();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("late_rvalid_ignored", {31'd0, wb_valid}, 32'd0);
        checkOutput("post_rst_idle", {31'd0, req_ready}, 32'd1);
        applyStimulus(OP_LW, 32'h300, 32'd0, 5'd5, 0, 0, 32'h12345678, 0, 4'b1111, 32'd0, 32'h12345678, 0);

        repeat (3) tick();
        checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
